// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper motor control blocks.
//   seq_state_t     : move sequencer state encoding
//   STEP_W_DEF      : default width of step counts and ramp counters
//   INTERVAL_W_DEF  : default width of driver interval values
package stepper_pkg;

  localparam int STEP_W_DEF     = 16;
  localparam int INTERVAL_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/step_event_detect.sv
// Detects one motor step from the driver's phase output.
//   clk, rst_n : clock, async active-low reset
//   step_drv   : driver phase output (4 bits)
//   motor_en   : driver enable as currently driven by the sequencer
//   step_evt   : strobe, high for one cycle when the phase changes while the
//                driver was enabled both in the previous and current cycle
// Requiring enable in both cycles rejects the driver clearing its phase to 0
// when it is switched off.
module step_event_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] step_drv,
  input  logic       motor_en,
  output logic       step_evt
);

  logic [3:0] step_q;
  logic       en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      en_q   <= 1'b0;
    end else begin
      step_q <= step_drv;
      en_q   <= motor_en;
    end
  end

  assign step_evt = en_q && motor_en && (step_q != step_drv);

endmodule

// File: rtl/stepper_move_sequencer.sv
// Move-level controller for the stepper driver: accepts one move command at
// a time and runs a linear accelerate / cruise / decelerate ramp, counting
// steps from the driver's phase output.
//   clk, rst_n          : clock, async active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_steps           : steps to move
//   cmd_reverse         : direction of the move
//   cmd_start_interval  : interval at start and end of the move (slowest)
//   cmd_min_interval    : cruise interval (fastest)
//   abort               : controlled stop request
//   step_drv            : driver phase output
//   motor_en, reverse, motor_interval : driver controls
//   busy                : move in progress
//   done                : one-cycle pulse at end of move
//   steps_remaining     : steps left in the current move
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ACCEL  | interval decremented on every step until it reaches min
// CRUISE | interval held at its current value
// DECEL  | interval incremented on every step back towards start
// DONE   | single-cycle end of move, done pulse
module stepper_move_sequencer
  import stepper_pkg::*;
#(
  parameter int STEP_W     = STEP_W_DEF,
  parameter int INTERVAL_W = INTERVAL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [STEP_W-1:0]     cmd_steps,
  input  logic                  cmd_reverse,
  input  logic [INTERVAL_W-1:0] cmd_start_interval,
  input  logic [INTERVAL_W-1:0] cmd_min_interval,
  input  logic                  abort,
  input  logic [3:0]            step_drv,
  output logic                  motor_en,
  output logic                  reverse,
  output logic [INTERVAL_W-1:0] motor_interval,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_W-1:0]     steps_remaining
);

  seq_state_t            state_q, state_d;
  logic [STEP_W-1:0]     rem_q, rem_d;
  logic [STEP_W-1:0]     acc_q, acc_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [INTERVAL_W-1:0] start_q, start_d;
  logic [INTERVAL_W-1:0] min_q, min_d;
  logic                  rev_q, rev_d;
  logic                  abort_q, abort_d;
  logic                  step_evt;
  logic                  moving_d;

  logic [STEP_W-1:0]     rem_dec;
  logic [INTERVAL_W-1:0] interval_inc;
  logic [INTERVAL_W-1:0] interval_dec;

  step_event_detect u_step_event_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_drv (step_drv),
    .motor_en (motor_en),
    .step_evt (step_evt)
  );

  // rem is at least 1 in every moving state, so the decrement cannot wrap.
  assign rem_dec      = rem_q - STEP_W'(1);
  assign interval_inc = (interval_q >= start_q) ? start_q : interval_q + INTERVAL_W'(1);
  // ACCEL is only entered with min < start and left once interval hits min.
  assign interval_dec = interval_q - INTERVAL_W'(1);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    interval_d = interval_q;
    start_d    = start_q;
    min_d      = min_q;
    rev_d      = rev_q;
    abort_d    = abort_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rem_d      = cmd_steps;
          acc_d      = '0;
          interval_d = cmd_start_interval;
          start_d    = cmd_start_interval;
          min_d      = cmd_min_interval;
          rev_d      = cmd_reverse;
          abort_d    = 1'b0;
          if (cmd_steps == '0)
            state_d = S_DONE;
          else if (cmd_min_interval >= cmd_start_interval)
            state_d = S_CRUISE;
          else
            state_d = S_ACCEL;
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (step_evt) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            state_d = S_DONE;
          end else if (state_q == S_DECEL) begin
            // An aborted move stops on the first step once back at start speed.
            if (abort_q && (interval_q == start_q))
              state_d = S_DONE;
            else
              interval_d = interval_inc;
          end else if (rem_dec <= acc_q) begin
            state_d    = S_DECEL;
            interval_d = interval_inc;
          end else if (state_q == S_ACCEL) begin
            interval_d = interval_dec;
            acc_d      = acc_q + STEP_W'(1);
            if (interval_dec == min_q)
              state_d = S_CRUISE;
          end
        end
        // Abort is applied after the step rules of the same cycle.
        if (abort && (state_q != S_DECEL) && (state_d != S_DONE)) begin
          state_d = S_DECEL;
          abort_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign moving_d = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      acc_q      <= '0;
      interval_q <= '0;
      start_q    <= '0;
      min_q      <= '0;
      rev_q      <= 1'b0;
      abort_q    <= 1'b0;
      motor_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      interval_q <= interval_d;
      start_q    <= start_d;
      min_q      <= min_d;
      rev_q      <= rev_d;
      abort_q    <= abort_d;
      motor_en   <= moving_d;
      busy       <= moving_d;
      done       <= (state_d == S_DONE);
      cmd_ready  <= (state_d == S_IDLE);
    end
  end

  assign reverse         = rev_q;
  assign motor_interval  = interval_q;
  assign steps_remaining = rem_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Self-checking bench for stepper_move_sequencer. Expected interval/remaining
// steps for each step event are pushed to a scoreboard queue when a move is
// started and popped as each step is driven.
module tb_stepper_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_reverse;
  logic [7:0]  cmd_start_interval;
  logic [7:0]  cmd_min_interval;
  logic        abort;
  logic [3:0]  step_drv;
  logic        motor_en;
  logic        reverse;
  logic [7:0]  motor_interval;
  logic        busy;
  logic        done;
  logic [15:0] steps_remaining;

  typedef struct {
    int interval;
    int rem;
    bit done;
  } exp_t;

  exp_t       sb[$];
  int         checks_total  = 0;
  int         checks_passed = 0;
  logic [3:0] phase = 4'd0;

  always #5 clk = ~clk;

  stepper_move_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_steps          (cmd_steps),
    .cmd_reverse        (cmd_reverse),
    .cmd_start_interval (cmd_start_interval),
    .cmd_min_interval   (cmd_min_interval),
    .abort              (abort),
    .step_drv           (step_drv),
    .motor_en           (motor_en),
    .reverse            (reverse),
    .motor_interval     (motor_interval),
    .busy               (busy),
    .done               (done),
    .steps_remaining    (steps_remaining)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int interval, input int rem, input bit d);
    exp_t e;
    e.interval = interval;
    e.rem      = rem;
    e.done     = d;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input int steps, input bit rev, input int start, input int mn);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid          = 1'b1;
    cmd_steps          = 16'(steps);
    cmd_reverse        = rev;
    cmd_start_interval = 8'(start);
    cmd_min_interval   = 8'(mn);
    tick();
    cmd_valid = 1'b0;
    chk("accept_ready_low", 32'(cmd_ready), 32'd0);
    chk("accept_reverse", 32'(reverse), 32'(rev));
    if (steps == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_motor_en", 32'(motor_en), 32'd0);
      tick();
      chk("zero_done_clear", 32'(done), 32'd0);
      chk("zero_ready_back", 32'(cmd_ready), 32'd1);
      chk("zero_motor_en2", 32'(motor_en), 32'd0);
    end else begin
      chk("accept_motor_en", 32'(motor_en), 32'd1);
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_interval", 32'(motor_interval), 32'(start));
      chk("accept_rem", 32'(steps_remaining), 32'(steps));
      // let the enable be seen for a full cycle before the first phase change
      tick();
    end
  endtask

  // Drive one phase change; optionally mimic the driver clearing its phase
  // right after it is disabled at the end of the move.
  task automatic step_once(input bit clear_after);
    exp_t e;
    @(negedge clk);
    phase    = (phase == 4'd0 || phase == 4'd8) ? 4'd1 : (phase << 1);
    step_drv = phase;
    tick();
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("step_interval", 32'(motor_interval), 32'(e.interval));
    chk("step_rem", 32'(steps_remaining), 32'(e.rem));
    chk("step_done", 32'(done), 32'(e.done));
    chk("step_motor_en", 32'(motor_en), 32'(!e.done));
    if (e.done) begin
      if (clear_after) begin
        step_drv = 4'd0;
        phase    = 4'd0;
      end
      tick();
      chk("done_single_cycle", 32'(done), 32'd0);
      chk("ready_after_done", 32'(cmd_ready), 32'd1);
      chk("rem_after_done", 32'(steps_remaining), 32'(e.rem));
    end else begin
      tick();
      chk("hold_rem", 32'(steps_remaining), 32'(e.rem));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n              = 1'b0;
    cmd_valid          = 1'b0;
    cmd_steps          = '0;
    cmd_reverse        = 1'b0;
    cmd_start_interval = '0;
    cmd_min_interval   = '0;
    abort              = 1'b0;
    step_drv           = 4'd0;
    repeat (3) tick();
    chk("rst_motor_en", 32'(motor_en), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reverse", 32'(reverse), 32'd0);
    chk("rst_interval", 32'(motor_interval), 32'd0);
    chk("rst_rem", 32'(steps_remaining), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full ramp: 9, 8, 7 (cruise), 8, 9, then done
    push(9, 5, 0); push(8, 4, 0); push(7, 3, 0);
    push(8, 2, 0); push(9, 1, 0); push(9, 0, 1);
    send_cmd(6, 1'b0, 10, 7);
    repeat (6) step_once(1'b0);

    // zero-step command
    send_cmd(0, 1'b1, 9, 3);

    // no ramp, reverse direction
    push(5, 2, 0); push(5, 1, 0); push(5, 0, 1);
    send_cmd(3, 1'b1, 5, 5);
    chk("noramp_reverse", 32'(reverse), 32'd1);
    repeat (3) step_once(1'b0);

    // abort after three accelerating steps
    push(9, 99, 0); push(8, 98, 0); push(7, 97, 0);
    push(8, 96, 0); push(9, 95, 0); push(10, 94, 0); push(10, 93, 1);
    send_cmd(100, 1'b0, 10, 4);
    repeat (3) step_once(1'b0);
    @(negedge clk);
    abort = 1'b1;
    tick();
    chk("abort_interval_held", 32'(motor_interval), 32'd7);
    chk("abort_still_moving", 32'(motor_en), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    repeat (3) step_once(1'b0);
    // final step, then the driver clears its phase as it is disabled
    step_once(1'b1);
    repeat (2) tick();
    chk("glitch_rem_held", 32'(steps_remaining), 32'd93);
    chk("glitch_no_done", 32'(done), 32'd0);
    chk("glitch_idle_ready", 32'(cmd_ready), 32'd1);

    // reset during cruise
    push(6, 19, 0); push(6, 18, 0);
    send_cmd(20, 1'b1, 6, 6);
    repeat (2) step_once(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_motor_en", 32'(motor_en), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_reverse", 32'(reverse), 32'd0);
    chk("midrst_rem", 32'(steps_remaining), 32'd0);
    repeat (2) tick();
    chk("midrst_done_held", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 1, 0); push(3, 0, 1);
    send_cmd(2, 1'b0, 3, 3);
    repeat (2) step_once(1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
